// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Default bubble instruction (addi x0, x0, 0).
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Low address bits that must be zero for a word-aligned fetch target.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline latch: flush inserts a bubble, load captures a fetched
// instruction, otherwise contents hold.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus4;
  logic [XLEN-1:0] r_instr;

  // Latch update: flush has priority over load; neither means hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
      r_instr    <= NOP_INSTR;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc_plus4;
      r_instr    <= i_instr;
    end
  end

  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_instr    = r_instr;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory read address and
// fills the IF/ID register. Handles stall, redirect, wrap-around and faulting
// redirects. Optional perf counters: define FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter longint unsigned MEM_BYTES = 128,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] instruction_code,
  output logic [XLEN-1:0] pc,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            fetch_fault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] bubble_count
`endif
);

  // MEM_BYTES is a power of two, so this keeps exactly the in-range bits.
  localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(MEM_BYTES - 1);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_target_bad;
  logic            w_load;
  logic            w_flush;

  assign w_pc_plus4   = (r_pc + 32'd4) & ADDR_MASK;
  assign w_target_bad = ((redirect_target[1:0] & ALIGN_MASK) != 2'b00) ||
                        ((redirect_target & ~ADDR_MASK) != '0);

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WARMUP;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next state, next PC and IF/ID controls; redirect beats stall in RUN.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    case (r_state)
      WARMUP: w_state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (w_target_bad) begin
            w_state_next = FAULT;
          end else begin
            w_pc_next = redirect_target;
          end
        end else if (!stall) begin
          w_load    = 1'b1;
          w_pc_next = w_pc_plus4;
        end
      end
      FAULT:   w_state_next = FAULT;
      default: w_state_next = WARMUP;
    endcase
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (reset),
    .i_load    (w_load),
    .i_flush   (w_flush),
    .i_pc      (r_pc),
    .i_pc_plus4(w_pc_plus4),
    .i_instr   (instruction_code),
    .o_valid   (if_id_valid),
    .o_pc      (if_id_pc),
    .o_pc_plus4(if_id_pc_plus4),
    .o_instr   (if_id_instr)
  );

  assign pc          = r_pc;
  assign fetch_fault = (r_state == FAULT);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [XLEN-1:0] r_fetch_count;
  logic [XLEN-1:0] r_bubble_count;
  logic            w_bubble_evt;

  assign w_bubble_evt = (r_state == RUN) && (redirect_valid || stall);

  // Saturating counters; events only occur in RUN, so FAULT freezes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_load && (r_fetch_count != '1)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_bubble_evt && (r_bubble_count != '1)) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign fetch_count  = r_fetch_count;
  assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a behavioural model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned MEMB = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction_code;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        fetch_fault;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  assign instruction_code = mem[pc[6:2]];

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(128),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instruction_code(instruction_code),
    .pc              (pc),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr),
    .fetch_fault     (fetch_fault)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count     (fetch_count),
    .bubble_count    (bubble_count)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural view of fetch behaviour.
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fetch, m_bubble;
  bit          m_valid, m_warm, m_fault;

  function automatic void model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP;
    m_valid = 1'b0; m_warm = 1'b1; m_fault = 1'b0;
    m_fetch = 32'h0; m_bubble = 32'h0;
  endfunction

  function automatic void model_edge(input bit st, input bit rv, input logic [31:0] tgt);
    if (m_warm) begin
      m_warm = 1'b0;
    end else if (!m_fault) begin
      if (rv || st) m_bubble++;
      if (rv) begin
        m_valid = 1'b0;
        m_instr = NOP;
        if ((tgt % 4) != 0 || tgt >= MEMB) m_fault = 1'b1;
        else                               m_pc = tgt;
      end else if (!st) begin
        m_fetch++;
        m_valid = 1'b1;
        m_ipc   = m_pc;
        m_instr = mem[m_pc / 4];
        m_ipc4  = (m_pc + 4) % MEMB;
        m_pc    = (m_pc + 4) % MEMB;
      end
    end
  endfunction

  task automatic compare_all(input string where);
    check({where, ":pc"},    pc,                 m_pc);
    check({where, ":valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    check({where, ":instr"}, if_id_instr,        m_instr);
    check({where, ":fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    if (m_valid) begin
      check({where, ":ifpc"},  if_id_pc,       m_ipc);
      check({where, ":ifpc4"}, if_id_pc_plus4, m_ipc4);
    end
`ifdef FETCH_PERF_COUNTERS_EN
    check({where, ":fcnt"}, fetch_count,  m_fetch);
    check({where, ":bcnt"}, bubble_count, m_bubble);
`endif
  endtask

  task automatic step(input bit st, input bit rv, input logic [31:0] tgt);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    model_edge(st, rv, tgt);
    #1 compare_all("step");
  endtask

  task automatic random_steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic [31:0] t;
      t = 32'($urandom_range(0, 31)) * 32'd4;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0020_81B3;
    mem[1] = 32'h0020_91B3;
    mem[8] = 32'h4020_A1B3;
    mem[9] = 32'h4020_B1B3;

    // Reset held for three cycles; values apply with no edge.
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #1 model_reset();
    compare_all("reset");
    check("reset:ifpc",  if_id_pc,       32'h0);
    check("reset:ifpc4", if_id_pc_plus4, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1 compare_all("reset_hold");
    end
    reset = 1'b0;

    step(1'b1, 1'b1, 32'h40);          // warmup ignores stall/redirect
    check("warm:valid", {31'b0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, '0);
    check("first:instr", if_id_instr, 32'h0020_81B3);
    check("first:pc",    pc,          32'h4);
    step(1'b0, 1'b0, '0);

    // Stall with pc = 8.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("stall:pc",    pc,          32'h8);
    check("stall:instr", if_id_instr, 32'h0020_91B3);
    repeat (10) step(1'b0, 1'b0, '0);

    // Redirect wins over stall.
    step(1'b1, 1'b1, 32'h24);
    check("redir:pc",    pc, 32'h24);
    check("redir:valid", {31'b0, if_id_valid}, 32'h0);
    step(1'b0, 1'b0, '0);
    check("redir:instr", if_id_instr, 32'h4020_B1B3);

    // Wrap-around at the top of memory.
    step(1'b0, 1'b1, 32'h7C);
    check("wrap:pc0", pc, 32'h7C);
    step(1'b0, 1'b0, '0);
    check("wrap:pc1",   pc,             32'h0);
    check("wrap:ifpc",  if_id_pc,       32'h7C);
    check("wrap:ifpc4", if_id_pc_plus4, 32'h0);

    random_steps(300);

    // Misaligned redirect faults; FAULT ignores everything afterwards.
    step(1'b0, 1'b1, 32'h22);
    random_steps(5);
    check("fault:flag", {31'b0, fetch_fault}, 32'h1);

    // Async reset between edges clears state immediately.
    #3 reset = 1'b1;
    #1 model_reset();
    compare_all("async_rst_fault");
    @(posedge clk);
    #1 reset = 1'b0;

    // Out-of-range redirect also faults.
    random_steps(20);
    step(1'b0, 1'b1, 32'h80);
    check("oor:fault", {31'b0, fetch_fault}, 32'h1);
    #3 reset = 1'b1;
    #1 model_reset();
    compare_all("async_rst_oor");
    @(posedge clk);
    #1 reset = 1'b0;

    // Mid-run reset with a nonzero PC.
    random_steps(12);
    step(1'b0, 1'b0, '0);
    #3 reset = 1'b1;
    #1 model_reset();
    compare_all("async_rst_run");
    check("async_rst_run:pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
